fc_input_streamer: RTL and testbench

FC_INPUT_STREAMER -- requirements
Module: fc_input_streamer

---
 rtl/fc_input_streamer.sv | 94 +++++++++
 tb/tb_fc_input_streamer.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/fc_input_streamer.sv
// fc_input_streamer: buffers one pooled frame channel-major, then streams it value by value to the fc stage.
// Define FCS_STALL_EN to let i_stall pause the stream without losing or repeating beats.
module fc_input_streamer #(
    parameter int I_BW   = 16,
    parameter int I_SIZE = 4,
    parameter int CI     = 12
) (
    input  logic                   clk,
    input  logic                   global_rst,
    input  logic                   user_reset,
    input  logic                   i_valid,
    input  logic [CI*I_BW-1:0]     i_data,
    input  logic                   i_stall,
    input  logic                   i_fc_end,
    output logic signed [I_BW-1:0] o_data,
    output logic                   o_ce,
    output logic                   o_ready,
    output logic                   o_overflow
);
    localparam int P  = I_SIZE * I_SIZE;
    localparam int N  = P * CI;
    localparam int PW = $clog2(P) + 1;
    localparam int IW = $clog2(N) + 1;
    localparam int AW = $clog2(N);

    typedef enum logic [1:0] {IDLE, FILL, STREAM, WAIT_FC} state_t;

    state_t          state, next;
    logic [PW-1:0]   pix;
    logic [IW-1:0]   idx;
    logic [I_BW-1:0] mem [N];
    logic            wr, last, stall, beat;

`ifdef FCS_STALL_EN
    assign stall = i_stall;
`else
    logic stall_unused;
    assign stall_unused = i_stall;
    assign stall = 1'b0;
`endif

    assign o_ready = (state == IDLE) || (state == FILL);
    assign wr      = i_valid && o_ready && !user_reset;
    assign last    = pix == PW'(P - 1);
    assign beat    = (state == STREAM) && (idx != IW'(N)) && !stall;

    always_ff @(posedge clk or posedge global_rst) begin
        if (global_rst) state <= IDLE;
        else            state <= next;
    end

    always_comb begin
        next = state;
        case (state)
            IDLE, FILL: next = wr ? (last ? STREAM : FILL) : state;
            STREAM:     next = (idx == IW'(N)) ? WAIT_FC : STREAM;
            WAIT_FC:    next = i_fc_end ? IDLE : WAIT_FC;
            default:    next = IDLE;
        endcase
        if (user_reset) next = IDLE;
    end

    // Channel-major layout so the stream order matches the fc weight index order.
    always_ff @(posedge clk) begin
        if (wr)
            for (int c = 0; c < CI; c++)
                mem[AW'(c * P) + AW'(pix)] <= i_data[c*I_BW +: I_BW];
    end

    always_ff @(posedge clk or posedge global_rst) begin
        if (global_rst) begin
            pix        <= '0;
            idx        <= '0;
            o_ce       <= 1'b0;
            o_data     <= '0;
            o_overflow <= 1'b0;
        end else if (user_reset) begin
            pix        <= '0;
            idx        <= '0;
            o_ce       <= 1'b0;
            o_data     <= '0;
            o_overflow <= 1'b0;
        end else begin
            if (i_valid && !o_ready) o_overflow <= 1'b1;
            if (wr) pix <= last ? '0 : pix + 1'b1;
            o_ce <= beat;
            if (beat) begin
                o_data <= mem[idx[AW-1:0]];
                idx    <= idx + 1'b1;
            end
            if (wr && last) idx <= '0;
        end
    end
endmodule

// File: tb/tb_fc_input_streamer.sv
// tb_fc_input_streamer: randomized frames against a channel-major reference model, checked by a scoreboard monitor.
module tb_fc_input_streamer;
    localparam int I_BW = 16, I_SIZE = 4, CI = 12, P = 16, N = 192;

    logic              clk = 0, global_rst = 0, user_reset = 0, i_valid = 0, i_stall = 0, i_fc_end = 0;
    logic [CI*I_BW-1:0] i_data = '0;
    logic [I_BW-1:0]   o_data;
    logic              o_ce, o_ready, o_overflow;

    int                chk = 0, err = 0, beats = 0, gaps = 0;
    logic [I_BW-1:0]   q[$];
    logic [I_BW-1:0]   last_exp = '0, exp_v;

    fc_input_streamer #(.I_BW(I_BW), .I_SIZE(I_SIZE), .CI(CI)) dut (
        .clk(clk), .global_rst(global_rst), .user_reset(user_reset), .i_valid(i_valid),
        .i_data(i_data), .i_stall(i_stall), .i_fc_end(i_fc_end), .o_data(o_data),
        .o_ce(o_ce), .o_ready(o_ready), .o_overflow(o_overflow));

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk++;
        if (act !== exp) begin
            err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (o_ce === 1'b1) begin
            if (q.size() == 0) begin
                chk++;
                err++;
                $display("FAIL beat_unexpected: got %0d expected no beat", o_data);
            end else begin
                exp_v = q.pop_front();
                check("beat", 32'(o_data), 32'(exp_v));
                last_exp = exp_v;
            end
            beats++;
        end else if (beats > 0 && q.size() > 0) gaps++;
    end

    // Reference: channel c of pixel p lands at c*P+p, and the stream reads indices 0..N-1 in order.
    task automatic send_frame(input bit pattern, input int spacing);
        logic [I_BW-1:0] st [N];
        logic [I_BW-1:0] v;
        beats = 0;
        gaps  = 0;
        @(negedge clk);
        for (int p = 0; p < P; p++) begin
            i_valid = 1;
            for (int c = 0; c < CI; c++) begin
                v = pattern ? I_BW'(p * 16 + c) : I_BW'($urandom);
                i_data[c*I_BW +: I_BW] = v;
                st[c*P + p] = v;
            end
            @(negedge clk);
            i_valid = 0;
            if (p < P - 1) repeat (spacing) @(negedge clk);
        end
        for (int k = 0; k < N; k++) q.push_back(st[k]);
        #1 check("ce_before_first", 32'(o_ce), 0);
        check("ready_in_stream", 32'(o_ready), 0);
        @(negedge clk);
        #1 check("ce_first", 32'(o_ce), 1);
    endtask

    task automatic wait_stream_end(input int exp_gaps);
        int n = 0;
        while ((q.size() > 0 || o_ce) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        #1 check("stream_timeout", 32'(n < 2000), 1);
        check("beat_count", 32'(beats), N);
        check("gap_cycles", 32'(gaps), 32'(exp_gaps));
        check("ce_after", 32'(o_ce), 0);
        check("data_hold", 32'(o_data), 32'(last_exp));
        check("ready_wait_fc", 32'(o_ready), 0);
    endtask

    task automatic end_fc();
        @(negedge clk);
        i_fc_end = 1;
        @(negedge clk);
        i_fc_end = 0;
        #1 check("ready_after_fc_end", 32'(o_ready), 1);
    endtask

    task automatic wait_beats(input int target, input string name);
        int n = 0;
        while (beats != target && n < 1000) begin
            @(negedge clk);
            #1 n++;
        end
        check(name, 32'(beats), 32'(target));
    endtask

    initial begin
        int exp_stall_gaps;
`ifdef FCS_STALL_EN
        exp_stall_gaps = 5;
`else
        exp_stall_gaps = 0;
`endif
        #1 global_rst = 1;
        #20;
        check("rst_ce", 32'(o_ce), 0);
        check("rst_ready", 32'(o_ready), 1);
        check("rst_overflow", 32'(o_overflow), 0);
        check("rst_data", 32'(o_data), 0);
        @(negedge clk);
        global_rst = 0;

        send_frame(1, 0);
        wait_stream_end(0);
        end_fc();

        send_frame(1, 2);
        wait_stream_end(0);
        end_fc();

        send_frame(0, 0);
        repeat (20) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            i_valid = 1;
            i_data  = {6{$urandom}};
            @(negedge clk);
        end
        i_valid = 0;
        #1 check("overflow_set", 32'(o_overflow), 1);
        wait_stream_end(0);
        end_fc();
        check("overflow_sticky", 32'(o_overflow), 1);

        send_frame(0, 0);
        wait_beats(50, "reach_beat50");
        user_reset = 1;
        @(negedge clk);
        user_reset = 0;
        #1 check("ureset_ce", 32'(o_ce), 0);
        check("ureset_ready", 32'(o_ready), 1);
        check("ureset_overflow", 32'(o_overflow), 0);
        q.delete();
        send_frame(0, 0);
        wait_stream_end(0);
        end_fc();

        send_frame(0, 0);
        wait_beats(100, "reach_beat100");
        i_stall = 1;
        repeat (5) @(negedge clk);
        i_stall = 0;
        wait_stream_end(exp_stall_gaps);
        end_fc();

        $display("Simulation finished: %0d checks, %0d errors", chk, err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end
endmodule
